axis_sample_player: RTL and testbench
=====================================

Name: axis_sample_player

Overview:
- Upstream source for the s1 input of the two-input AXIS output mux.
- Holds a small table of samples written by the control side. On start, it streams the table out over AXI-Stream a programmable number of times.
- Drives the mux select while playing so the output path switches from live data (s0) to the stored pattern and back.
- Used to inject calibration/probe waveforms into the DAC path.

Parameters:
- width, 16, sample/tdata width in bits.
- depth_log2, 8, log2 of table depth (256 entries).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  depth_log2  table write address
- wr_data  in  width  table write data
- len_in  in  depth_log2+1  samples per repetition, sampled on start
- reps_in  in  8  repetition count, sampled on start
- start  in  1  begin playback (level-sampled in IDLE)
- abort  in  1  stop at next beat boundary
- m_axis_tdata  out  width  sample
- m_axis_tvalid  out  1  sample valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  final beat of final repetition
- sel_out  out  1  mux select, 1 = this block owns output
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse on completion or abort

Behaviour:
- Reset values:
  - tvalid, tlast, sel_out, busy and done are 0; tdata is 0.
  - State is IDLE; all counters are 0.
  - Table contents are not reset.
- Table:
  - Single-clock RAM with synchronous read.
  - A write occurs when wr_en=1 and busy=0. Writes while busy are dropped.
- States: IDLE, PRELOAD, PLAY, FINISH.
- IDLE:
  - When start=1 and len_in!=0, latch len and reps (reps_in=0 treated as 1), set the index to 0, and go to PRELOAD.
  - When start=1 and len_in=0, stay in IDLE with no done pulse.
- PRELOAD (exactly 1 cycle):
  - sel_out=1 and busy=1; read of addr 0 issued; tvalid=0.
  - Next state is PLAY. The mux registers its select, so PRELOAD guarantees the select settles before the first beat.
- PLAY:
  - tvalid=1 and tdata=table[index].
  - A handshake is tvalid&tready. On a handshake, index advances; at len-1 it wraps to 0 and the repetition counter decrements.
  - Full throughput is required: one beat per cycle while tready=1.
  - tdata, tlast and tvalid are held stable while tvalid=1 and tready=0.
  - tlast=1 only on index=len-1 of the final repetition.
  - A handshake on the tlast beat moves the state to FINISH.
- FINISH (1 cycle):
  - tvalid=0, sel_out=0, done=1.
  - Next state is IDLE; busy drops on entry to IDLE.
- abort:
  - Ignored in IDLE.
  - In PRELOAD: go to FINISH, with no beat emitted.
  - In PLAY: latched. The current beat is held until its handshake, then the state goes to FINISH. tlast is not asserted for aborted streams.
  - Simultaneous with the tlast handshake: normal completion, identical result.
- start while busy is ignored. start and abort together in IDLE: start wins, and abort is not latched.
- Latency:
  - start at edge N gives sel_out=1 at N+1 and the first tvalid at N+2.
  - done comes 1 cycle after the final handshake.
  - Total cycles from start to done with tready held high: len*reps+2.
- Asynchronous reset mid-playback: all outputs go to reset values immediately, state goes to IDLE, and the table is preserved.

Test Plan:
- Write table[0..3]=0x0010,0x0020,0x0030,0x0040; len=4, reps=2, tready=1; start -> beats 10,20,30,40,10,20,30,40; tlast on 8th beat only; sel_out high 9 cycles; done at cycle 10 after start.
- Same setup, tready toggling 1,0,0,1 pattern -> no beat lost or duplicated; tdata/tvalid stable during stalls; 8 beats total.
- len=1, reps=0 -> exactly one beat table[0] with tlast=1; done 3 cycles after start when tready=1.
- len=4, reps=3, abort asserted on beat 5 with tready=0 for 2 cycles -> beat 5 held then accepted, no tlast, done next cycle, no further beats.
- wr_en to addr 0 with 0xFFFF during playback -> ignored; the next playback still outputs the original value. start with len_in=0 -> busy stays 0, no done.
- Assert reset low during PLAY -> tvalid, sel_out and busy go to 0 asynchronously; after release, a new start replays the unchanged table.

Source files
------------

// File: rtl/axis_sample_player_if.sv
// AXI-Stream beat channel used by the sample player output.
// The master drives data/valid/last and the slave returns ready.
interface axis_sample_player_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sample_player.sv
// Stores a small sample table and replays it over AXI-Stream a programmable
// number of times, owning the output mux select while it plays.
module axis_sample_player #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DEPTH_LOG2:0]     len_in,
  input  logic [7:0]              reps_in,
  input  logic                    start,
  input  logic                    abort,
  axis_sample_player_if.master    m_axis,
  output logic                    sel_out,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, PRELOAD, PLAY, FINISH} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DEPTH_LOG2:0]     len_q, len_d;
  logic [7:0]              reps_q, reps_d;
  logic                    abort_q, abort_d;

  logic [DATA_W-1:0]       mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0]       rdata_q;
  logic [DEPTH_LOG2-1:0]   rd_addr;
  logic                    at_end;
  logic                    last_rep;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      reps_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      reps_q  <= reps_d;
      abort_q <= abort_d;
    end
  end

  // Table RAM: synchronous read, content deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
    rdata_q <= mem[rd_addr];
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    reps_d        = reps_q;
    abort_d       = abort_q;
    rd_addr       = '0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tdata  = '0;
    sel_out       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    at_end        = ({1'b0, idx_q} == (len_q - 1'b1));
    last_rep      = (reps_q == 8'd1);

    case (state_q)
      IDLE: begin
        busy    = 1'b0;
        abort_d = 1'b0;
        if (start && (len_in != '0)) begin
          len_d   = len_in;
          reps_d  = (reps_in == 8'd0) ? 8'd1 : reps_in;
          idx_d   = '0;
          state_d = PRELOAD;
        end
      end
      PRELOAD: begin
        sel_out = 1'b1;
        state_d = abort ? FINISH : PLAY;
      end
      PLAY: begin
        sel_out       = 1'b1;
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = rdata_q;
        m_axis.tlast  = at_end && last_rep;
        rd_addr       = idx_q;
        if (m_axis.tready) begin
          if (at_end) begin
            idx_d  = '0;
            reps_d = reps_q - 8'd1;
          end else begin
            idx_d  = idx_q + 1'b1;
          end
          // Fetch the following sample now so the next beat is ready back-to-back.
          rd_addr = idx_d;
          if ((at_end && last_rep) || abort || abort_q) begin
            state_d = FINISH;
          end
        end else if (abort) begin
          abort_d = 1'b1;
        end
      end
      FINISH: begin
        done    = 1'b1;
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_sample_player.sv
// Bench for axis_sample_player: a queue-based beat model predicts every
// output cycle, plus literal expectations for the directed scenarios.
module tb_axis_sample_player;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int IDLE_P = 0, PRE_P = 1, PLAY_P = 2, FIN_P = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   len_in = '0;
  logic [7:0]    reps_in = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sel_out, busy, done;

  always #5 clk = ~clk;

  axis_sample_player_if #(.DATA_W(DW)) m_axis ();

  axis_sample_player #(.DATA_W(DW), .DEPTH_LOG2(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_in(len_in), .reps_in(reps_in), .start(start), .abort(abort),
    .m_axis(m_axis), .sel_out(sel_out), .busy(busy), .done(done)
  );

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] tbl [2**AW];
  beat_t q[$];
  logic [DW-1:0] hs_log[$];
  logic tl_log[$];
  int ph = IDLE_P;
  int ncyc = 0, start_cyc = 0, done_cyc = 0, hs_last = 0, reps_m = 0;
  int hs_cnt = 0, tlast_cnt = 0, sel_cnt = 0;
  logic done_seen = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic prev_l = 1'b0;
  logic [DW-1:0] lit [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl();
    return 32'({m_axis.tvalid, sel_out, busy, done});
  endfunction

  // Cycle compare against the beat-queue model, sampled mid-cycle.
  always @(negedge clk) begin
    ncyc++;
    if (!reset) begin
      chk("rst_ctl", ctl(), 32'h0);
      chk("rst_tdata", 32'(m_axis.tdata), 32'h0);
      chk("rst_tlast", 32'(m_axis.tlast), 32'h0);
      q.delete();
      ph = IDLE_P;
      stall_prev = 1'b0;
    end else begin
      if (sel_out) sel_cnt++;
      case (ph)
        IDLE_P: chk("idle_ctl", ctl(), 32'h0);
        PRE_P:  chk("preload_ctl", ctl(), 32'h6);
        FIN_P:  chk("finish_ctl", ctl(), 32'h3);
        default: begin
          chk("play_ctl", ctl(), 32'hE);
          if (q.size() == 0) chk("model_has_beat", 32'h0, 32'h1);
          else begin
            chk("tdata", 32'(m_axis.tdata), 32'(q[0].d));
            chk("tlast", 32'(m_axis.tlast), 32'(q[0].l));
          end
          if (stall_prev) begin
            chk("stall_tdata", 32'(m_axis.tdata), 32'(prev_d));
            chk("stall_tlast", 32'(m_axis.tlast), 32'(prev_l));
          end
        end
      endcase
      stall_prev = m_axis.tvalid && !m_axis.tready;
      prev_d = m_axis.tdata;
      prev_l = m_axis.tlast;

      case (ph)
        IDLE_P: begin
          if (wr_en) tbl[wr_addr] = wr_data;
          if (start && (len_in != '0)) begin
            reps_m = (reps_in == 8'd0) ? 1 : int'(reps_in);
            for (int k = 0; k < reps_m; k++)
              for (int i = 0; i < int'(len_in); i++)
                q.push_back('{tbl[AW'(i)], (k == reps_m - 1) && (i == int'(len_in) - 1)});
            ph = PRE_P;
            start_cyc = ncyc;
          end
        end
        PRE_P: begin
          if (abort) begin
            q.delete();
            ph = FIN_P;
          end else ph = PLAY_P;
        end
        PLAY_P: begin
          if (abort) while (q.size() > 1) void'(q.pop_back());
          if (m_axis.tready && q.size() > 0) begin
            hs_log.push_back(m_axis.tdata);
            tl_log.push_back(m_axis.tlast);
            if (m_axis.tlast) tlast_cnt++;
            hs_cnt++;
            hs_last = ncyc;
            void'(q.pop_front());
            if (q.size() == 0) ph = FIN_P;
          end
        end
        default: begin
          done_seen = 1'b1;
          done_cyc = ncyc;
          ph = IDLE_P;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    hs_log.delete();
    tl_log.delete();
    hs_cnt = 0; tlast_cnt = 0; sel_cnt = 0;
    done_seen = 1'b0; done_cyc = 0; start_cyc = 0; hs_last = 0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input int len, input int reps);
    len_in = (AW+1)'(len); reps_in = 8'(reps); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int mode, input int bound);
    int n;
    n = 0;
    while (!done_seen && n < bound) begin
      tick();
      case (mode)
        1: begin
          m_axis.tready = (n % 4 == 0) || (n % 4 == 3);
          wr_en = (n == 3); wr_addr = '0; wr_data = 16'hFFFF;
        end
        2: begin
          m_axis.tready = 1'($urandom_range(0, 1));
          abort   = ($urandom_range(0, 39) == 0);
          start   = ($urandom_range(0, 7) == 0);
          wr_en   = ($urandom_range(0, 2) == 0);
          wr_addr = AW'($urandom_range(0, 15));
          wr_data = DW'($urandom);
        end
        default: m_axis.tready = 1'b1;
      endcase
      n++;
    end
    start = 1'b0; abort = 1'b0; wr_en = 1'b0; m_axis.tready = 1'b1;
    if (!done_seen) chk("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic chk_lit_seq();
    chk("seq_len", 32'(hs_log.size()), 32'd8);
    for (int i = 0; i < hs_log.size() && i < 8; i++)
      chk("seq_data", 32'(hs_log[i]), 32'(lit[i % 4]));
    if (tl_log.size() == 8) chk("seq_tlast_8th", 32'(tl_log[7]), 32'h1);
    chk("seq_tlast_cnt", 32'(tlast_cnt), 32'd1);
  endtask

  initial begin
    int n;
    m_axis.tready = 1'b0;
    #12;
    chk("reset_ctl", ctl(), 32'h0);
    chk("reset_tdata", 32'(m_axis.tdata), 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    m_axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) wr(i, lit[i]);

    // Basic two-repetition playback at full throughput.
    clear(); go(4, 2); wait_done(0, 50);
    chk_lit_seq();
    chk("t1_sel_cycles", 32'(sel_cnt), 32'd9);
    chk("t1_done_offset", 32'(done_cyc - start_cyc), 32'd10);

    // Stalling sink plus a dropped write to address 0.
    clear(); go(4, 2); wait_done(1, 100);
    chk_lit_seq();

    // Single beat, reps_in=0 counts as one repetition.
    clear(); go(1, 0); wait_done(0, 20);
    chk("t3_beats", 32'(hs_cnt), 32'd1);
    if (hs_log.size() > 0) chk("t3_data", 32'(hs_log[0]), 32'h0010);
    chk("t3_tlast_cnt", 32'(tlast_cnt), 32'd1);
    chk("t3_done_offset", 32'(done_cyc - start_cyc), 32'd3);

    // Abort on beat 5 while stalled for two cycles.
    clear(); go(4, 3);
    n = 0;
    while (hs_cnt < 4 && n < 100) begin tick(); n++; end
    m_axis.tready = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0;
    tick(); m_axis.tready = 1'b1;
    wait_done(0, 50);
    chk("t4_beats", 32'(hs_cnt), 32'd5);
    if (hs_log.size() == 5) chk("t4_beat5", 32'(hs_log[4]), 32'h0010);
    chk("t4_tlast_cnt", 32'(tlast_cnt), 32'd0);
    chk("t4_done_after_hs", 32'(done_cyc - hs_last), 32'd1);

    // Abort during the preload cycle.
    clear(); go(4, 1); abort = 1'b1; tick(); abort = 1'b0; wait_done(0, 20);
    chk("t5_beats", 32'(hs_cnt), 32'd0);
    chk("t5_done_offset", 32'(done_cyc - start_cyc), 32'd2);

    // Zero length start does nothing.
    clear(); go(0, 1); tick(); tick();
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_no_done", 32'(done_seen), 32'h0);

    // Asynchronous reset mid-playback, then replay.
    clear(); go(4, 2);
    n = 0;
    while (hs_cnt < 3 && n < 100) begin tick(); n++; end
    #1 reset = 1'b0;
    #1;
    chk("t7_async_ctl", ctl(), 32'h0);
    chk("t7_async_tdata", 32'(m_axis.tdata), 32'h0);
    tick(); tick(); reset = 1'b1;
    clear(); go(4, 2); wait_done(0, 50);
    chk_lit_seq();

    // Randomised playbacks against the model.
    for (int a = 0; a < 16; a++) wr(a, DW'($urandom));
    for (int t = 0; t < 30; t++) begin
      int l, r;
      l = $urandom_range(0, 10);
      r = $urandom_range(0, 3);
      clear();
      abort = ($urandom_range(0, 3) == 0);
      go(l, r);
      abort = 1'b0;
      if (l == 0) begin
        tick();
        chk("rand_len0_busy", 32'(busy), 32'h0);
      end else wait_done(2, 2000);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
